// File: rtl/pi_sample_sequencer_if.sv
// ---------------------------------------------------------------------------
// pi_sample_sequencer_if
// Sample/result bus between the pi run controller and the circle checker.
//   chk_valid         sample valid (controller -> checker)
//   chk_x, chk_y      16-bit sample coordinates (controller -> checker)
//   chk_result_valid  checker output valid (checker -> controller)
//   chk_result        1 = sample lies inside the circle (checker -> controller)
// Modports: master = sequencer side, slave = checker side.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface pi_sample_sequencer_if;
    logic        chk_valid;
    logic [15:0] chk_x;
    logic [15:0] chk_y;
    logic        chk_result_valid;
    logic        chk_result;

    modport master (
        output chk_valid, chk_x, chk_y,
        input  chk_result_valid, chk_result
    );

    modport slave (
        input  chk_valid, chk_x, chk_y,
        output chk_result_valid, chk_result
    );
endinterface

// File: rtl/pi_sample_sequencer.sv
// ---------------------------------------------------------------------------
// pi_sample_sequencer
// Run controller for the Monte Carlo pi estimator. On an accepted start it
// issues sample_count random (x, y) samples, one per clock, to the circle
// checker, counts the in-circle results coming back and pulses done once
// every result has been received. pi ~= 4 * hit_count / total_count.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   start          run request, only looked at in IDLE
//   sample_count   samples per run, captured on accepted start
//   seed           (PI_EST_SEED_LOAD_EN only) LFSR load value on start,
//                  0 selects LFSR_SEED
//   busy           high while issuing or draining
//   done           one-cycle pulse at run completion
//   hit_count      in-circle results of the last/current run
//   total_count    results received in the last/current run
//   chk            checker bus (master side)
//
// Optional feature macro: PI_EST_SEED_LOAD_EN (adds the seed port).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module pi_sample_sequencer #(
    parameter int          CNT_W     = 32,
    parameter int          CHK_LAT   = 2,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     sample_count,
`ifdef PI_EST_SEED_LOAD_EN
    input  logic [31:0]          seed,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     hit_count,
    output logic [CNT_W-1:0]     total_count,
    pi_sample_sequencer_if.master chk
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    state_t           state;
    logic [CNT_W-1:0] n_lat;     // run length latched on start
    logic [CNT_W-1:0] issued;    // samples issued so far in this run
    logic [31:0]      lfsr;
    logic [31:0]      lfsr_next;
    logic [31:0]      load_val;  // LFSR value the first sample of a run uses
    logic             acc_en;
    logic [CNT_W-1:0] total_nxt;
    logic [CNT_W-1:0] hit_nxt;

    // Right-shifting Galois LFSR, x^32 + x^22 + x^2 + x + 1
    always_comb begin
        lfsr_next = {1'b0, lfsr[31:1]};
        if (lfsr[0])
            lfsr_next = lfsr_next ^ LFSR_MASK;
    end

`ifdef PI_EST_SEED_LOAD_EN
    assign load_val = (seed == 32'd0) ? LFSR_SEED : seed;
`else
    // No reseed: a new run continues the sequence where the last one stopped.
    assign load_val = lfsr;
`endif

    // Results only count while a run is in progress; anything arriving in
    // IDLE/DONE (e.g. leftovers from a reset-aborted run) is dropped.
    assign acc_en = chk.chk_result_valid && (state == ISSUE || state == DRAIN);

    always_comb begin
        total_nxt = total_count;
        hit_nxt   = hit_count;
        if (acc_en) begin
            total_nxt = total_count + CNT_W'(1);
            if (chk.chk_result)
                hit_nxt = hit_count + CNT_W'(1);
        end
    end

    assign busy = (state == ISSUE) || (state == DRAIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            n_lat         <= '0;
            issued        <= '0;
            lfsr          <= LFSR_SEED;
            done          <= 1'b0;
            hit_count     <= '0;
            total_count   <= '0;
            chk.chk_valid <= 1'b0;
            chk.chk_x     <= '0;
            chk.chk_y     <= '0;
        end else begin
            done        <= 1'b0;
            hit_count   <= hit_nxt;
            total_count <= total_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        n_lat       <= sample_count;
                        issued      <= '0;
                        hit_count   <= '0;
                        total_count <= '0;
                        lfsr        <= load_val;
                        if (sample_count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state         <= ISSUE;
                            chk.chk_valid <= 1'b1;
                            chk.chk_x     <= load_val[31:16];
                            chk.chk_y     <= load_val[15:0];
                        end
                    end
                end
                ISSUE: begin
                    // The LFSR steps once per issued sample so the next
                    // sample is presented from the freshly advanced state.
                    issued <= issued + CNT_W'(1);
                    lfsr   <= lfsr_next;
                    // Compare against N-1 so N = 2^CNT_W-1 never wraps issued.
                    if (issued == n_lat - CNT_W'(1)) begin
                        chk.chk_valid <= 1'b0;
                        if (total_nxt == n_lat) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        chk.chk_x <= lfsr_next[31:16];
                        chk.chk_y <= lfsr_next[15:0];
                    end
                end
                DRAIN: begin
                    // Look ahead one result so done lands the cycle after
                    // the last result arrives.
                    if (total_nxt == n_lat) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    // A result during a run must correspond to a sample sent CHK_LAT earlier.
    generate
        if (CHK_LAT > 0) begin : g_lat_chk
            a_result_latency: assert property (
                @(posedge clk) disable iff (rst)
                (chk.chk_result_valid && busy) |-> $past(chk.chk_valid, CHK_LAT)
            );
        end
    endgenerate
`endif

endmodule
